// File: rtl/noc_pkg.sv
// noc_pkg: flit format, head fields and expected payload pattern shared by the NoC generator and checker.
package noc_pkg;
    localparam int FLIT_W   = 34;
    localparam int PAY_W    = 32;
    localparam int TYPE_LSB = 32;
    typedef enum logic [1:0] {
        FT_NONE = 2'b00,
        FT_HEAD = 2'b01,
        FT_BODY = 2'b10,
        FT_TAIL = 2'b11
    } flit_type_e;
    typedef struct packed {
        logic [3:0] dst_x;
        logic [3:0] dst_y;
        logic [3:0] src_x;
        logic [3:0] src_y;
        logic [7:0] seq;
        logic [7:0] len;
    } head_t;
    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DRAIN} state_e;
    function automatic logic [PAY_W-1:0] exp_word(input logic [7:0] seq, input logic [3:0] src_x,
                                                  input logic [3:0] src_y, input logic [7:0] k);
        return {seq, src_x, src_y, k, ~k};
    endfunction
endpackage

// File: rtl/noc_seq_table.sv
// noc_seq_table: per-source expected sequence numbers, one async read port and one write port.
module noc_seq_table #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/noc_pkt_checker.sv
// noc_pkt_checker: ejection-port sink that checks routing, sequence, framing and payload of incoming packets.
module noc_pkt_checker import noc_pkg::*; #(
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0,
    parameter int NX      = 2,
    parameter int NY      = 2,
    parameter int MAX_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              stall,
    output logic              in_ready,
    output logic              error_led,
    output logic              error_con,
    output logic              pkt_done,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       err_cnt
);
    localparam int DEPTH = NX * NY;
    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    state_e     state, nxt;
    flit_type_e ft;
    head_t      h;
    logic [7:0] k, len, seq, tdata;
    logic [3:0] sx, sy;
    logic [AW-1:0] taddr;
    logic en, acc, bad, src_ok, len_ok, dst_bad, seq_bad, last, word_bad, ok_pos, ec, el, done;
    assign ft       = flit_type_e'(in_flit[FLIT_W-1:TYPE_LSB]);
    assign h        = in_flit[PAY_W-1:0];
    assign in_ready = en & ~stall;
    assign acc      = in_valid & in_ready;
    assign src_ok   = int'(h.src_x) < NX && int'(h.src_y) < NY;
    assign len_ok   = h.len != 8'd0 && int'(h.len) <= MAX_LEN;
    assign dst_bad  = h.dst_x != 4'(MY_X) || h.dst_y != 4'(MY_Y);
    assign taddr    = AW'(int'(h.src_y) * NX + int'(h.src_x));
    assign seq_bad  = h.seq != tdata;
    assign last     = k == len - 8'd1;
    assign word_bad = in_flit[PAY_W-1:0] != exp_word(seq, sx, sy, k);
    // a body before the last slot or a tail exactly at it is the only in-frame flit
    assign ok_pos   = ft != FT_NONE && (ft == FT_TAIL) == last;
    noc_seq_table #(.DEPTH(DEPTH), .AW(AW)) u_seq (
        .clk   (clk),
        .reset (reset),
        .raddr (taddr),
        .rdata (tdata),
        .we    (acc && ft == FT_HEAD && src_ok),
        .waddr (taddr),
        .wdata (h.seq + 8'd1)
    );
    always_ff @(posedge clk) state <= reset ? S_IDLE : nxt;
    always_comb begin
        nxt = state;
        if (acc) begin
            if (ft == FT_HEAD) nxt = (src_ok && len_ok) ? S_BODY : S_DRAIN;
            else if (state == S_BODY && ft == FT_TAIL) nxt = S_IDLE;
            else if (state == S_BODY && ft == FT_BODY && last) nxt = S_DRAIN;
            else if (state == S_DRAIN && ft == FT_TAIL) nxt = S_IDLE;
        end
    end
    always_comb begin
        ec   = 1'b0;
        el   = 1'b0;
        done = 1'b0;
        if (acc) begin
            if (ft == FT_HEAD) begin
                ec = state == S_BODY || !src_ok || !len_ok || dst_bad;
                el = src_ok && seq_bad;
            end else if (state == S_IDLE) begin
                ec = 1'b1;
            end else if (state == S_BODY) begin
                ec   = !ok_pos;
                el   = ok_pos && word_bad;
                done = ok_pos && last && !bad && !word_bad;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            en        <= 1'b0;
            k         <= '0;
            len       <= '0;
            seq       <= '0;
            sx        <= '0;
            sy        <= '0;
            bad       <= 1'b0;
            error_led <= 1'b0;
            error_con <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            en <= 1'b1;
            if (acc && ft == FT_HEAD) begin
                k   <= '0;
                len <= h.len;
                seq <= h.seq;
                sx  <= h.src_x;
                sy  <= h.src_y;
                bad <= dst_bad | seq_bad;
            end else if (acc && state == S_BODY) begin
                k   <= k + 8'd1;
                bad <= bad | el;
            end
            error_con <= error_con | ec;
            error_led <= error_led | el;
            pkt_done  <= done;
            if ((ec | el) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (done && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_noc_pkt_checker.sv
// tb_noc_pkt_checker: directed and randomized packet traffic checked against a packet-level reference model.
module tb_noc_pkt_checker;
    localparam int MY_X = 0, MY_Y = 0, NX = 2, NY = 2, MAX_LEN = 8;
    logic clk = 1'b0, reset, in_valid, stall, in_ready, error_led, error_con, pkt_done;
    logic [33:0] in_flit;
    logic [15:0] pkt_cnt, err_cnt;
    int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0, stall_mode = 0;
    int m_tab[NX*NY];
    bit m_in, m_drain, m_bad, m_led, m_con, m_done;
    int m_len, m_k, m_seq, m_sx, m_sy, m_pkt, m_err;

    noc_pkt_checker #(.MY_X(MY_X), .MY_Y(MY_Y), .NX(NX), .NY(NY), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit), .stall(stall),
        .in_ready(in_ready), .error_led(error_led), .error_con(error_con), .pkt_done(pkt_done),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expw(input int sq, input int sx, input int sy, input int k);
        return 32'(sq * 16777216 + sx * 1048576 + sy * 65536 + k * 256 + (255 - k));
    endfunction

    function automatic void model_reset();
        foreach (m_tab[i]) m_tab[i] = 0;
        {m_in, m_drain, m_bad, m_led, m_con, m_done} = '0;
        {m_len, m_k, m_seq, m_sx, m_sy, m_pkt, m_err} = '{default: 0};
    endfunction

    // Reference: apply one accepted flit to the packet-level view of the receiver.
    function automatic void model(input logic [33:0] f);
        int typ, sx, sy, sq, ln, idx;
        bit con, led, dbad;
        typ = int'(f[33:32]);
        con = 0; led = 0; m_done = 0;
        if (typ == 1) begin
            sx = int'(f[23:20]); sy = int'(f[19:16]); sq = int'(f[15:8]); ln = int'(f[7:0]);
            dbad = int'(f[31:28]) != MY_X || int'(f[27:24]) != MY_Y;
            con = m_in || dbad;
            if (sx < NX && sy < NY) begin
                idx = sy * NX + sx;
                led = sq != m_tab[idx];
                m_tab[idx] = (sq + 1) % 256;
            end
            if (sx >= NX || sy >= NY || ln == 0 || ln > MAX_LEN) begin
                con = 1; m_in = 0; m_drain = 1;
            end else begin
                m_in = 1; m_drain = 0; m_len = ln; m_k = 0;
                m_seq = sq; m_sx = sx; m_sy = sy; m_bad = dbad || led;
            end
        end else if (m_in) begin
            if (typ == 0) con = 1;
            else if (typ == 3 && m_k != m_len - 1) begin con = 1; m_in = 0; end
            else if (typ == 2 && m_k == m_len - 1) begin con = 1; m_in = 0; m_drain = 1; end
            else begin
                if (f[31:0] != expw(m_seq, m_sx, m_sy, m_k)) begin led = 1; m_bad = 1; end
                m_k++;
                if (typ == 3) begin
                    m_in = 0;
                    if (!m_bad) m_done = 1;
                end
            end
        end else if (m_drain) begin
            if (typ == 3) m_drain = 0;
        end else con = 1;
        m_con |= con;
        m_led |= led;
        if ((con || led) && m_err < 65535) m_err++;
        if (m_done && m_pkt < 65535) m_pkt++;
    endfunction

    task automatic send(input logic [33:0] f);
        int n;
        logic took;
        n = 0;
        took = 1'b0;
        while (!took && n < 200) begin
            @(negedge clk);
            stall = stall_mode == 1 ? cyc[1] : stall_mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
            in_valid = 1'b1;
            in_flit = stall ? {2'($urandom), 32'($urandom)} : f;
            #1 took = in_ready;
            n++;
        end
        chk("accept", 32'(took), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (took) begin
            model(f);
            chk("pkt_done", 32'(pkt_done), 32'(m_done));
            chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            chk("error_led", 32'(error_led), 32'(m_led));
            chk("error_con", 32'(error_con), 32'(m_con));
        end
    endtask

    // Head plus nsent flits; the last is a tail when tail_end, word bad_k is corrupted.
    task automatic send_pkt(input int dx, input int dy, input int sx, input int sy, input int sq,
                            input int ln, input int nsent, input int bad_k, input bit tail_end);
        logic [31:0] w;
        send({2'b01, 4'(dx), 4'(dy), 4'(sx), 4'(sy), 8'(sq), 8'(ln)});
        for (int i = 0; i < nsent; i++) begin
            w = (i == bad_k) ? 32'hDEADBEEF : expw(sq % 256, sx, sy, i % 256);
            send({(tail_end && i == nsent - 1) ? 2'b11 : 2'b10, w});
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_led"}, 32'(error_led), 32'd0);
        chk({tag, "_con"}, 32'(error_con), 32'd0);
        chk({tag, "_done"}, 32'(pkt_done), 32'd0);
        chk({tag, "_pkt"}, 32'(pkt_cnt), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int kind, sx, sy, sq, ln, ns;
        reset = 1'b1; in_valid = 1'b0; in_flit = '0; stall = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_reset", 32'(in_ready), 32'd1);

        send_pkt(0, 0, 1, 0, 0, 3, 3, -1, 1);
        chk("first_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("first_flags", 32'({error_led, error_con}), 32'd0);

        stall_mode = 1;
        send_pkt(0, 0, 1, 1, 0, 4, 4, -1, 1);
        send_pkt(0, 0, 1, 1, 1, 2, 2, -1, 1);
        stall_mode = 0;
        chk("stall_pkt_cnt", 32'(pkt_cnt), 32'd3);
        chk("stall_err_cnt", 32'(err_cnt), 32'd0);

        send_pkt(0, 0, 1, 0, 5, 2, 2, -1, 1);
        chk("seq_led", 32'(error_led), 32'd1);
        chk("seq_err_cnt", 32'(err_cnt), 32'd1);
        send_pkt(0, 0, 1, 0, 6, 2, 2, -1, 1);
        chk("resync_err_cnt", 32'(err_cnt), 32'd1);
        chk("resync_pkt_cnt", 32'(pkt_cnt), 32'd4);

        send_pkt(0, 0, 0, 1, 0, 3, 3, 1, 1);
        chk("corrupt_pkt_cnt", 32'(pkt_cnt), 32'd4);
        chk("corrupt_err_cnt", 32'(err_cnt), 32'd2);

        send_pkt(0, 0, 0, 0, 0, 3, 2, -1, 1);
        chk("early_tail_con", 32'(error_con), 32'd1);
        send_pkt(0, 0, 0, 0, 1, 2, 2, -1, 1);
        chk("after_early_pkt_cnt", 32'(pkt_cnt), 32'd5);

        send_pkt(0, 0, 1, 0, 7, 0, 2, -1, 1);
        chk("len0_err_cnt", 32'(err_cnt), 32'd4);
        send({2'b11, 32'h1234_5678});
        chk("stray_tail_err_cnt", 32'(err_cnt), 32'd5);

        stall_mode = 2;
        for (int p = 0; p < 60; p++) begin
            kind = $urandom_range(0, 11);
            sx = $urandom_range(0, NX - 1);
            sy = $urandom_range(0, NY - 1);
            sq = m_tab[sy * NX + sx];
            ln = $urandom_range(1, MAX_LEN);
            case (kind)
                0: send_pkt(0, 0, sx, sy, sq, ln, ln, $urandom_range(0, ln - 1), 1);
                1: send_pkt(0, 0, sx, sy, (sq + $urandom_range(1, 200)) % 256, ln, ln, -1, 1);
                2: send_pkt(1, $urandom_range(0, 1), sx, sy, sq, ln, ln, -1, 1);
                3: send_pkt(0, 0, sx, sy, sq, ln + 1, ln, -1, 1);
                4: send_pkt(0, 0, sx, sy, sq, ln, ln + 1, -1, 1);
                5: send_pkt(0, 0, sx, sy, sq, 0, $urandom_range(1, 3), -1, 1);
                6: send_pkt(0, 0, sx, sy, sq, $urandom_range(MAX_LEN + 1, 255), $urandom_range(1, 3), -1, 1);
                7: send_pkt(0, 0, $urandom_range(NX, 15), sy, sq, ln, ln, -1, 1);
                8: send({($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11, 32'($urandom)});
                9: begin
                    ns = $urandom_range(0, ln - 1);
                    send_pkt(0, 0, sx, sy, sq, ln, ns, -1, 0);
                end
                default: send_pkt(0, 0, sx, sy, sq, ln, ln, -1, 1);
            endcase
        end
        stall_mode = 0;

        send_pkt(0, 0, 1, 0, m_tab[1], 3, 1, -1, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 check_idle_outputs("mid_reset");
        model_reset();
        @(negedge clk) reset = 1'b0;
        send_pkt(0, 0, 1, 0, 0, 3, 3, -1, 1);
        chk("post_reset_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("post_reset_err_cnt", 32'(err_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/noc_pkt_checker.md
Name: noc_pkt_checker

Overview:
- Sink and checker at a router's local ejection port. It is the receiving end of the packet generator that injects traffic on `send_en`.
- Accepts flits over a valid/ready handshake and checks destination, per-source sequence number, length framing and body payload pattern.
- Drives sticky `error_led` (data/sequence errors) and `error_con` (protocol/routing errors), plus packet and error counters, for board LEDs and the bench.

Parameters:
- MY_X, 0, this node's X coordinate (4 bits used)
- MY_Y, 0, this node's Y coordinate (4 bits used)
- NX, 2, mesh width; valid source X range is 0..NX-1
- NY, 2, mesh height; valid source Y range is 0..NY-1
- MAX_LEN, 8, maximum body+tail flits per packet (1..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  flit valid from router local output
- in_flit  in  34  [33:32] type (00 none, 01 head, 10 body, 11 tail); [31:0] payload
- stall  in  1  test backpressure; forces in_ready low
- in_ready  out  1  flit accepted when in_valid & in_ready
- error_led  out  1  sticky: data or sequence error seen
- error_con  out  1  sticky: protocol, routing or length error seen
- pkt_done  out  1  one-cycle pulse: error-free packet completed
- pkt_cnt  out  16  error-free packets received, saturating
- err_cnt  out  16  error events, saturating

Behaviour:
- Interface decision: one clock `clk`; `reset` is synchronous, active-high. All state updates on the rising edge of `clk` only.
- Reset values: all outputs 0; FSM in IDLE; sequence table all 0. `in_ready` is a registered enable ANDed with `~stall`. The registered enable is 0 during reset and 1 from the first cycle after reset deasserts.
- Head payload fields:
  - [31:28] dst_x, [27:24] dst_y
  - [23:20] src_x, [19:16] src_y
  - [15:8] seq, [7:0] len (number of body+tail flits that follow)
- Expected body/tail word k (k = 0..len-1) = {seq[7:0], src_x, src_y, k[7:0], ~k[7:0]}.
- FSM states:
  - IDLE: expect head. Head with len in 1..MAX_LEN and src in range → BODY, k=0. Head with len=0, len>MAX_LEN or src out of range → error_con, DRAIN. Body, tail or type 00 with valid → error_con, flit dropped, stay IDLE.
  - BODY: body accepted while k<len-1 → check word, k++. Tail accepted at k==len-1 → check word, IDLE.
    - Tail at k<len-1 → error_con, IDLE.
    - Body at k==len-1 → error_con, DRAIN.
    - Head → error_con, current packet aborted (not counted), head processed as in IDLE in the same cycle.
  - DRAIN: discard until tail (→ IDLE). A head in DRAIN is processed as in IDLE.
- Destination mismatch (dst != MY_X/MY_Y) → error_con; the packet is still framed and checked.
- Sequence check: seq != table[src_y*NX+src_x] → error_led. Table entry is set to seq+1 (mod 256) on every valid head (resync).
- Data mismatch on any body/tail word → error_led; the packet is marked bad.
- Latency: error flags and `err_cnt` update the cycle after the offending flit is accepted. `pkt_done` and `pkt_cnt` update the cycle after the tail of a packet with no errors.
- Multiple errors on the same flit increment `err_cnt` by exactly 1.
- Counters saturate at 0xFFFF. Error flags clear only on reset.
- Flits presented while in_ready=0 are not consumed and not checked.
- Reset mid-packet: immediate return to IDLE; the partial packet is discarded with no flags.

Decomposition:
- Shared package `noc_pkg`:
  - flit_type_e enum
  - FLIT_W=34, field widths/offsets
  - head_t packed struct
  - function exp_word(seq, src_x, src_y, k), shared with the generator so both ends agree
- One sub-module `noc_seq_table`: NX*NY × 8-bit register file, one read port and one write port, synchronous reset to 0.

Test Plan:
- Head {dst=0,0, src=1,0, seq=0, len=3}, bodies 0x00100_0FF/01FE, tail k=2 correct → pkt_done pulse, pkt_cnt=1, both error flags 0.
- Two back-to-back packets from src(1,1) with seq 0 then 1, stall toggling every 2 cycles → no flit lost, pkt_cnt=2, no errors.
- Second packet from src(1,0) with seq=5 instead of 1 → error_led=1, err_cnt=1; next packet with seq=6 → no new error.
- Body word k=1 corrupted to 0xDEADBEEF → error_led=1, pkt_done not pulsed, pkt_cnt unchanged.
- Tail after 1 flit when len=3 → error_con=1, FSM IDLE; following good packet counted (pkt_cnt+1).
- Head with len=0, then body, tail → error_con=1, err_cnt=1, flits discarded; reset asserted mid-packet → all outputs 0 the next cycle.
